// File: rtl/serdes_rx_aligner_if.sv
// Lane-side bundle for the receive word aligner: control, ISERDES data in, and status out.
interface serdes_rx_aligner_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  en;
    logic                  restart;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  bitslip;
    logic                  locked;
    logic                  fail;
    logic [2:0]            state;
    logic [7:0]            slip_count;
    logic [15:0]           err_count;

    // Driver of control/data; observer of status.
    modport master (
        output en, restart, data_in, data_valid,
        input  bitslip, locked, fail, state, slip_count, err_count
    );

    // The aligner itself.
    modport slave (
        input  en, restart, data_in, data_valid,
        output bitslip, locked, fail, state, slip_count, err_count
    );
endinterface

// File: rtl/serdes_rx_aligner.sv
// Receive word aligner: slips the ISERDES until the training word lines up, then
// monitors the locked lane and falls back to searching after sustained mismatches.
module serdes_rx_aligner #(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'h6A,
    parameter int unsigned           MATCH_COUNT   = 4,
    parameter int unsigned           SLIP_WAIT     = 3,
    parameter int unsigned           MAX_SLIPS     = 16,
    parameter int unsigned           LOSS_LIMIT    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    serdes_rx_aligner_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSearch = 3'd1,
        StSlip   = 3'd2,
        StWait   = 3'd3,
        StLocked = 3'd4,
        StFail   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  loss_q, loss_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  slip_count_q, slip_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic word_ok;
    assign word_ok = (bus.data_in == TRAIN_PATTERN);

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            match_q      <= '0;
            loss_q       <= '0;
            wait_q       <= '0;
            slip_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            loss_q       <= loss_d;
            wait_q       <= wait_d;
            slip_count_q <= slip_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // Next-state and counter updates; en outranks restart, which outranks the FSM.
    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        loss_d       = loss_q;
        wait_d       = wait_q;
        slip_count_d = slip_count_q;
        err_count_d  = err_count_q;

        if (!bus.en) begin
            state_d      = StIdle;
            match_d      = '0;
            loss_d       = '0;
            wait_d       = '0;
            slip_count_d = '0;
        end else if (bus.restart) begin
            state_d      = StSearch;
            match_d      = '0;
            loss_d       = '0;
            wait_d       = '0;
            slip_count_d = '0;
            err_count_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSearch;
                StSearch: begin
                    // Invalid words leave the match run intact.
                    if (bus.data_valid) begin
                        if (word_ok) begin
                            match_d = match_q + 4'd1;
                            if (32'(match_q) + 32'd1 == MATCH_COUNT) begin
                                state_d = StLocked;
                                match_d = '0;
                                loss_d  = '0;
                            end
                        end else begin
                            match_d = '0;
                            state_d = (32'(slip_count_q) == MAX_SLIPS) ? StFail : StSlip;
                        end
                    end
                end
                StSlip: begin
                    if (slip_count_q != 8'hFF) slip_count_d = slip_count_q + 8'd1;
                    wait_d  = 4'(SLIP_WAIT);
                    state_d = StWait;
                end
                StWait: begin
                    // Data is ignored while the ISERDES settles after a slip.
                    wait_d = wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        wait_d  = '0;
                        state_d = StSearch;
                    end
                end
                StLocked: begin
                    if (bus.data_valid) begin
                        if (word_ok) begin
                            loss_d = '0;
                        end else begin
                            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                            loss_d = loss_q + 4'd1;
                            if (32'(loss_q) + 32'd1 == LOSS_LIMIT) begin
                                state_d      = StSearch;
                                slip_count_d = '0;
                                match_d      = '0;
                                loss_d       = '0;
                            end
                        end
                    end
                end
                StFail: state_d = StFail;
                default: state_d = StIdle;
            endcase
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        bus.bitslip    = (state_q == StSlip);
        bus.locked     = (state_q == StLocked);
        bus.fail       = (state_q == StFail);
        bus.state      = state_q;
        bus.slip_count = slip_count_q;
        bus.err_count  = err_count_q;
    end

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// Bench for serdes_rx_aligner: a rotating ISERDES model feeds the aligner, expected
// bitslip pulses are queued per scenario and retired by a pulse monitor.
module tb_serdes_rx_aligner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serdes_rx_aligner_if #(.DATA_WIDTH(8)) bus ();

    serdes_rx_aligner #(
        .DATA_WIDTH   (8),
        .TRAIN_PATTERN(8'h6A),
        .MATCH_COUNT  (4),
        .SLIP_WAIT    (3),
        .MAX_SLIPS    (16),
        .LOSS_LIMIT   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected slip_count value seen during each upcoming bitslip pulse.
    logic [31:0] exp_q[$];

    logic [7:0] tx_word = 8'h00;
    int         rot = 0;
    int         rot_base = 0;

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [15:0] t;
        t = {w, w} << (n % 8);
        return t[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ISERDES model: each bitslip rotates the captured word left by one bit.
    always @(posedge clk) if (bus.bitslip === 1'b1) rot <= rot + 1;
    always_comb bus.data_in = rotl8(tx_word, rot - rot_base);

    // Pulse monitor: every pulse must be expected, and pulses must be spaced >= 5 cycles.
    int cyc = 0;
    int last_cyc = 0;
    bit have_last = 1'b0;
    always @(negedge clk) begin
        if (bus.bitslip === 1'b1) begin
            chk("bitslip_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("slip_count_at_pulse", 32'(bus.slip_count), exp_q.pop_front());
            if (have_last) chk("slip_spacing", 32'(cyc - last_cyc >= 5), 32'd1);
            have_last = 1'b1;
            last_cyc  = cyc;
        end
        cyc++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        for (int n = 0; n < max; n++) begin
            if (bus.state == s) break;
            cycle();
        end
        chk(tag, 32'(bus.state), 32'(s));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_bitslip"}, 32'(bus.bitslip), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
        chk({tag, "_fail"}, 32'(bus.fail), 32'd0);
        chk({tag, "_slip_count"}, 32'(bus.slip_count), 32'd0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.restart    = 1'b0;
        bus.data_valid = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // 1: reset state, then enable.
        chk_reset_outputs("reset");
        bus.en = 1'b1;
        cycle();
        chk("enable_search", 32'(bus.state), 32'd1);

        // 2: aligned data with two invalid cycles between matches.
        tx_word  = 8'h6A;
        rot_base = rot;
        for (int i = 0; i < 4; i++) begin
            bus.data_valid = 1'b1;
            cycle();
            bus.data_valid = 1'b0;
            chk("aligned_locked", 32'(bus.locked), (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) begin
                cycle();
                cycle();
            end
        end
        chk("aligned_slip_count", 32'(bus.slip_count), 32'd0);

        // 3: misaligned by three bit positions.
        tx_word     = rotl8(8'h6A, 5);
        rot_base    = rot;
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        chk("restart_search", 32'(bus.state), 32'd1);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i));
        bus.data_valid = 1'b1;
        wait_state(3'd4, 200, "misaligned_lock_state");
        chk("misaligned_slip_count", 32'(bus.slip_count), 32'd3);
        chk("misaligned_locked", 32'(bus.locked), 32'd1);
        chk("misaligned_pulses_left", 32'(exp_q.size()), 32'd0);

        // 4: constant zero never aligns: 16 slips then FAIL.
        tx_word     = 8'h00;
        rot_base    = rot;
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
        wait_state(3'd5, 300, "zero_fail_state");
        chk("zero_fail_flag", 32'(bus.fail), 32'd1);
        chk("zero_slip_count", 32'(bus.slip_count), 32'd16);
        chk("zero_pulses_left", 32'(exp_q.size()), 32'd0);
        repeat (10) cycle();
        chk("fail_sticky", 32'(bus.state), 32'd5);
        bus.data_valid = 1'b0;
        bus.restart    = 1'b1;
        cycle();
        bus.restart = 1'b0;
        chk("fail_restart_state", 32'(bus.state), 32'd1);
        chk("fail_restart_flag", 32'(bus.fail), 32'd0);
        chk("fail_restart_slips", 32'(bus.slip_count), 32'd0);

        // 5: errors while locked, then loss of lock.
        tx_word        = 8'h6A;
        rot_base       = rot;
        bus.data_valid = 1'b1;
        wait_state(3'd4, 20, "relock_state");
        tx_word = 8'h00;
        repeat (3) cycle();
        tx_word = 8'h6A;
        cycle();
        chk("err3_count", 32'(bus.err_count), 32'd3);
        chk("err3_locked", 32'(bus.locked), 32'd1);
        tx_word = 8'h55;
        repeat (3) cycle();
        chk("err6_locked", 32'(bus.locked), 32'd1);
        cycle();
        bus.data_valid = 1'b0;
        chk("loss_err_count", 32'(bus.err_count), 32'd7);
        chk("loss_locked", 32'(bus.locked), 32'd0);
        chk("loss_state", 32'(bus.state), 32'd1);
        chk("loss_slip_count", 32'(bus.slip_count), 32'd0);

        // en=0 idles the lane but keeps the error history.
        bus.en = 1'b0;
        cycle();
        chk("disable_state", 32'(bus.state), 32'd0);
        chk("disable_err_hold", 32'(bus.err_count), 32'd7);
        bus.en = 1'b1;
        cycle();
        chk("reenable_state", 32'(bus.state), 32'd1);

        // 6a: asynchronous reset during WAIT.
        tx_word        = 8'h00;
        rot_base       = rot;
        exp_q.push_back(32'd0);
        bus.data_valid = 1'b1;
        wait_state(3'd3, 20, "reach_wait");
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_wait");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("wait_release_state", 32'(bus.state), 32'd0);

        // 6b: asynchronous reset in the middle of the bitslip cycle.
        wait_state(3'd2, 20, "reach_slip");
        chk("slip_pulse_high", 32'(bus.bitslip), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_slip");
        bus.data_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("slip_release_state", 32'(bus.state), 32'd0);
        repeat (4) cycle();
        chk("final_pulses_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
